// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with write bypass and pending-write scoreboard
module regfile_sb #(
   parameter int XLEN     = 32,
   parameter int NREG     = 32,
   parameter int AW       = 5,
   parameter int NRD      = 2,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NRD*AW-1:0]    rd_addr,
   output logic [NRD*XLEN-1:0]  rd_data,
   output logic [NRD-1:0]       rd_busy,
   input  logic                 we,
   input  logic [AW-1:0]        wr_addr,
   input  logic [XLEN-1:0]      wr_data,
   input  logic                 iss_valid,
   input  logic [AW-1:0]        iss_addr,
   output logic [NREG*XLEN-1:0] registers,
   output logic [NREG-1:0]      busy
);
   logic [XLEN-1:0] r_x [NREG];
   logic [NREG-1:0] r_busy;
   logic            w_wr_ok;
   logic            w_iss_ok;

   function automatic logic f_valid(input logic [AW-1:0] a);
      return (32'(a) < 32'(NREG)) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   assign w_wr_ok  = we && f_valid(wr_addr);
   assign w_iss_ok = iss_valid && f_valid(iss_addr);

   // issue is applied after the write clear so a new producer supersedes the retiring one
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NREG; k++) r_x[k] <= '0;
         r_busy <= '0;
      end else begin
         if (w_wr_ok) begin
            r_x[wr_addr]    <= wr_data;
            r_busy[wr_addr] <= 1'b0;
         end
         if (w_iss_ok) r_busy[iss_addr] <= 1'b1;
      end
   end

   genvar g;
   generate
      for (g = 0; g < NRD; g++) begin : g_rd
         logic [AW-1:0] w_a;
         logic          w_ok;
         logic          w_hit;
         assign w_a   = rd_addr[g*AW +: AW];
         assign w_ok  = f_valid(w_a);
         assign w_hit = (BYPASS != 0) && we && (wr_addr == w_a) && w_ok;
         assign rd_data[g*XLEN +: XLEN] = !w_ok ? '0 : w_hit ? wr_data : r_x[w_a];
         assign rd_busy[g] = w_ok && !w_hit && r_busy[w_a];
      end
      for (g = 0; g < NREG; g++) begin : g_dump
         assign registers[g*XLEN +: XLEN] = r_x[g];
      end
   endgenerate

   assign busy = r_busy;
endmodule
